// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, sequencer states and the key-event record
// shared by the PS/2 keyboard sequencer and its event FIFO.
package ps2_pkg;

    localparam logic [7:0] PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PREFIX_BRK   = 8'hF0;
    localparam logic [7:0] PREFIX_PAUSE = 8'hE1;

    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CTRL   = 8'h14;
    localparam logic [7:0] KEY_ALT    = 8'h11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_evt_t;

    localparam int EVT_W = $bits(key_evt_t);

    // Bytes the keyboard sends as command responses rather than key data.
    function automatic logic is_dev_resp(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return b inside {PREFIX_EXT, PREFIX_BRK, PREFIX_PAUSE};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous key-event FIFO; head is presented directly and
// reads as zero while empty.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [EVT_W-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [EVT_W-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [EVT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_wr, do_rd;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d = mem_q;
        if (do_wr) mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        cnt_d    = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: resolves E0/F0/E1 prefix sequences into key events, tracks modifiers.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of the last make.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000,
    parameter int FIFO_DEPTH  = 4,
    parameter int PAUSE_SKIP  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_code_new,
    input  logic [7:0] ps2_code,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int SW = $clog2(PAUSE_SKIP + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t          state_q, state_d;
    logic [SW-1:0]   skip_q, skip_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      shift_q, shift_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [1:0]      alt_q, alt_d;
    logic            ovf_q, ovf_d;
    logic            emit, push;
    key_evt_t        evt, head;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        emit     = 1'b0;
        evt.code = ps2_code;
        evt.ext  = 1'b0;
        evt.brk  = 1'b0;
        tmo_d    = (ps2_code_new || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;
        if (ps2_code_new) begin
            case (state_q)
                S_IDLE: begin
                    if (ps2_code == PREFIX_EXT) state_d = S_EXT;
                    else if (ps2_code == PREFIX_BRK) state_d = S_BRK;
                    else if (ps2_code == PREFIX_PAUSE) begin
                        state_d = S_SKIP;
                        skip_d  = SW'(PAUSE_SKIP);
                    end else emit = !is_dev_resp(ps2_code);
                end
                S_EXT: begin
                    evt.ext = 1'b1;
                    if (ps2_code == PREFIX_BRK) state_d = S_EXT_BRK;
                    else if (ps2_code != PREFIX_EXT) begin
                        emit    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    evt.ext = state_q == S_EXT_BRK;
                    evt.brk = 1'b1;
                    emit    = !is_prefix(ps2_code);
                    state_d = S_IDLE;
                end
                S_SKIP: begin
                    skip_d  = skip_q - 1'b1;
                    state_d = (skip_q == SW'(1)) ? S_IDLE : S_SKIP;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = S_IDLE;
        end
    end

    // Index 1 holds the right-hand key (E0-prefixed for Ctrl/Alt, 59 for Shift).
    always_comb begin
        shift_d = shift_q;
        ctrl_d  = ctrl_q;
        alt_d   = alt_q;
        if (emit && !evt.ext && evt.code == KEY_LSHIFT) shift_d[0] = !evt.brk;
        if (emit && !evt.ext && evt.code == KEY_RSHIFT) shift_d[1] = !evt.brk;
        if (emit && evt.code == KEY_CTRL) ctrl_d[evt.ext] = !evt.brk;
        if (emit && evt.code == KEY_ALT) alt_d[evt.ext] = !evt.brk;
        ovf_d = ovf_q | (push && fifo_full);
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make_q, last_make_d;
    logic       last_vld_q, last_vld_d;
    logic       same_key;

    always_comb begin
        same_key    = last_vld_q && last_make_q == {evt.ext, evt.code};
        last_make_d = (emit && !evt.brk) ? {evt.ext, evt.code} : last_make_q;
        last_vld_d  = (emit && !evt.brk) ? 1'b1 : (emit && same_key) ? 1'b0 : last_vld_q;
        push        = emit && !(same_key && !evt.brk);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_make_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            last_make_q <= last_make_d;
            last_vld_q  <= last_vld_d;
        end
    end
`else
    assign push = emit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            shift_q <= '0;
            ctrl_q  <= '0;
            alt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            shift_q <= shift_d;
            ctrl_q  <= ctrl_d;
            alt_q   <= alt_d;
            ovf_q   <= ovf_d;
        end
    end

    ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push && fifo_count < CW'(FIFO_DEPTH)),
        .wr_data (evt),
        .rd_en   (evt_valid && evt_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign evt_valid = !fifo_empty;
    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign mod_shift = |shift_q;
    assign mod_ctrl  = |ctrl_q;
    assign mod_alt   = |alt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed scan-code sequences with hand-computed expected events.
module tb_ps2_kbd_ctrl;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_code_new = 1'b0;
    logic [7:0] ps2_code = 8'h00;
    logic       evt_ready = 1'b0;
    logic       evt_valid, evt_ext, evt_break;
    logic [7:0] evt_code;
    logic       mod_shift, mod_ctrl, mod_alt, overflow;

    int n_chk = 0;
    int n_pass = 0;
    int pop_cnt = 0;
    int p0;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(4), .PAUSE_SKIP(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_code_new (ps2_code_new),
        .ps2_code     (ps2_code),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_code     (evt_code),
        .evt_ext      (evt_ext),
        .evt_break    (evt_break),
        .mod_shift    (mod_shift),
        .mod_ctrl     (mod_ctrl),
        .mod_alt      (mod_alt),
        .overflow     (overflow)
    );

    always @(posedge clk) if (evt_valid && evt_ready) pop_cnt <= pop_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        ps2_code     = b;
        ps2_code_new = 1'b1;
        @(negedge clk);
        ps2_code_new = 1'b0;
    endtask

    task automatic chk_evt(input string tag, input logic [7:0] c, input logic e, input logic b);
        chk({tag, ".valid"}, 32'(evt_valid), 32'd1);
        chk({tag, ".code"}, 32'(evt_code), 32'(c));
        chk({tag, ".ext_brk"}, 32'({evt_ext, evt_break}), 32'({e, b}));
    endtask

    initial begin
        logic [7:0] ovf_codes [5];
        ovf_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h35};
        repeat (3) tick();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt", 32'({evt_code, evt_ext, evt_break}), 32'd0);
        chk("rst_mods_ovf", 32'({mod_shift, mod_ctrl, mod_alt, overflow}), 32'd0);
        rst = 1'b0;
        evt_ready = 1'b1;

        send(8'h1C); chk_evt("make1c", 8'h1C, 1'b0, 1'b0);
        tick(); chk("make1c_one_cycle", 32'(evt_valid), 32'd0);
        send(8'hF0); chk("brk_prefix_quiet", 32'(evt_valid), 32'd0);
        send(8'h1C); chk_evt("brk1c", 8'h1C, 1'b0, 1'b1);
        tick(); chk("brk1c_one_cycle", 32'(evt_valid), 32'd0);

        send(8'hE0); send(8'h75); chk_evt("ext75", 8'h75, 1'b1, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h75); chk_evt("extbrk75", 8'h75, 1'b1, 1'b1);

        send(8'h12); chk_evt("lshift", 8'h12, 1'b0, 1'b0);
        chk("shift_on", 32'(mod_shift), 32'd1);
        send(8'hF0); send(8'h12); chk("shift_off", 32'(mod_shift), 32'd0);
        send(8'hE0); send(8'h14); chk("rctrl_on", 32'(mod_ctrl), 32'd1);
        send(8'h14);
        send(8'hE0); send(8'hF0); send(8'h14); chk("lctrl_still_held", 32'(mod_ctrl), 32'd1);
        send(8'hF0); send(8'h14); chk("ctrl_off", 32'(mod_ctrl), 32'd0);
        send(8'h11); chk("alt_on", 32'(mod_alt), 32'd1);
        send(8'hF0); send(8'h11); chk("alt_off", 32'(mod_alt), 32'd0);

        send(8'hF0); send(8'hE0); send(8'h75); chk_evt("brk_proto_err", 8'h75, 1'b0, 1'b0);

        tick();
        p0 = pop_cnt;
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        chk("pause_no_ctrl", 32'(mod_ctrl), 32'd0);
        send(8'h1C); chk_evt("after_pause", 8'h1C, 1'b0, 1'b0);
        tick(); chk("pause_pops", 32'(pop_cnt - p0), 32'd1);
        p0 = pop_cnt;
        send(8'hFA); send(8'hAA); tick();
        chk("devresp_pops", 32'(pop_cnt - p0), 32'd0);

        send(8'hE0); repeat (TO - 1) tick();
        send(8'h2C); chk_evt("timeout", 8'h2C, 1'b0, 1'b0);
        send(8'hE0); repeat (TO - 2) tick();
        send(8'h75); chk_evt("timeout_edge", 8'h75, 1'b1, 1'b0);

        send(8'hE0);
        rst = 1'b1; tick(); rst = 1'b0;
        send(8'h75); chk_evt("rst_mid_seq", 8'h75, 1'b0, 1'b0);

        tick();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ovf_codes[i]);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        send(ovf_codes[4]);
        chk("ovf_set", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_evt($sformatf("drain%0d", i), ovf_codes[i], 1'b0, 1'b0);
            tick();
        end
        chk("drained", 32'(evt_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("ovf_rst", 32'(overflow), 32'd0);

        p0 = pop_cnt;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
        tick();
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("typematic_pops", 32'(pop_cnt - p0), 32'd3);
`else
        chk("typematic_pops", 32'(pop_cnt - p0), 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
Scan-code sequencer behind ps2_keyboard. Consumes the raw byte stream (ps2_code_new/ps2_code) and resolves E0 (extended), F0 (break) and E1 (pause) prefix sequences into single key events. Tracks Shift/Ctrl/Alt modifier state and buffers events in a small FIFO with a valid/ready handshake toward the CPU/terminal logic.

Parameters:
TIMEOUT_CYC, 100000, idle cycles after a prefix byte before the partial sequence is abandoned (2 ms at 50 MHz)
FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2
PAUSE_SKIP, 7, bytes discarded after an E1 prefix

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ps2_code_new  in  1  single-cycle strobe; ps2_code is valid on this cycle
ps2_code  in  8  received scan-code byte
evt_valid  out  1  FIFO head holds an event
evt_ready  in  1  consumer accepts the head event when evt_valid is high
evt_code  out  8  key scan code, prefixes stripped
evt_ext  out  1  event was E0-prefixed
evt_break  out  1  1 = key release, 0 = key press
mod_shift  out  1  left or right Shift currently held
mod_ctrl  out  1  left or right Ctrl currently held
mod_alt  out  1  left or right Alt currently held
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst high at a clk edge): FSM goes to IDLE, FIFO empties, timeout counter and modifiers clear. evt_valid, mod_*, overflow all = 0. evt_code/evt_ext/evt_break = 0.
- Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. All transitions occur only on ps2_code_new, except timeout.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP, with skip count = PAUSE_SKIP.
  - 00, AA, EE, FA, FC, FD, FE, FF are device responses: dropped, stay in IDLE.
  - Any other byte: emit {code, ext=0, brk=0}.
- EXT:
  - F0 -> EXT_BRK.
  - E0 -> stay in EXT.
  - Other byte: emit {code, 1, 0} -> IDLE.
- BRK:
  - E0, F0 or E1 is a protocol error: -> IDLE, no emit.
  - Other byte: emit {code, 0, 1} -> IDLE.
- EXT_BRK:
  - E0, F0 or E1: -> IDLE, no emit.
  - Other byte: emit {code, 1, 1} -> IDLE.
- SKIP: each byte decrements the count; the byte that brings it to 0 returns the FSM to IDLE. No emits in SKIP.
- Timeout:
  - Counter clears on every ps2_code_new and while in IDLE.
  - In any non-IDLE state, reaching TIMEOUT_CYC-1 forces IDLE with no emit.
  - ps2_code_new on the same cycle wins; that byte is processed normally.
- Modifiers:
  - Updated on the emit cycle, independent of FIFO space.
  - Shift: 12 or 59 with ext=0.
  - Ctrl: 14, either ext value (left and right tracked separately).
  - Alt: 11, either ext value (left and right tracked separately).
  - Press sets the bit; release clears it. mod_* is the OR of left and right.
- FIFO write: an emit writes when the FIFO count before this cycle is below FIFO_DEPTH.
  - Otherwise the event is dropped and overflow sets.
  - A pop on the same cycle does not rescue a write when full.
- FIFO read: pop when evt_valid && evt_ready. evt_* outputs show the head entry, registered. Simultaneous push and pop with the FIFO not full both take effect.
- Latency: ps2_code_new at edge N completing an event with the FIFO empty -> evt_valid=1 with that event after edge N+1.
- overflow clears only on rst.

Optional Feature:
PS2_TYPEMATIC_FILTER_EN
- Defined:
  - A register last_make {ext,code} holds the most recent make event.
  - A make equal to last_make is suppressed (no FIFO write).
  - A break matching last_make clears last_make to invalid.
  - Modifier tracking is unaffected.
- Undefined: every typematic repeat is emitted as a fresh make; no last_make register is built.

Decomposition:
- Package ps2_pkg:
  - Scan-code constants: PREFIX_EXT=E0, PREFIX_BRK=F0, PREFIX_PAUSE=E1, the device-response code list, and the modifier codes 12/59/14/11.
  - FSM state enum.
  - Packed key-event struct {code[7:0], ext, brk}.
- One sub-module, ps2_evt_fifo: synchronous FIFO parameterised by FIFO_DEPTH, with full/empty/count outputs. The FSM, timeout and modifier logic stay in ps2_kbd_ctrl.

Test Plan:
- Bytes 1C; F0 1C with evt_ready=1 -> events {1C,0,0} then {1C,0,1}; evt_valid high for 1 cycle each; first one asserted the cycle after strobe.
- Bytes E0 75; E0 F0 75 -> {75,1,0} then {75,1,1}; bytes 12 then F0 12 -> mod_shift 1 after the first event, 0 after the release.
- Bytes E1 14 77 E1 F0 14 F0 77 then 1C -> only {1C,0,0} emitted; bytes FA and AA alone -> no events.
- Byte E0, then TIMEOUT_CYC idle cycles, then 1C -> FSM back in IDLE; event {1C,0,0} (ext=0).
- evt_ready=0 and 5 make codes with FIFO_DEPTH=4 -> 4 entries held, the 5th dropped, overflow=1; drain returns the first 4 in order; overflow stays 1 until rst.
- With PS2_TYPEMATIC_FILTER_EN: bytes 1C 1C 1C F0 1C 1C -> {1C,0,0}, {1C,0,1}, {1C,0,0}. Without the macro: 5 events.
